// File: rtl/cpu_pkg.sv
// Shared CPU-wide defaults and the fetch-state encoding.
package cpu_pkg;

  localparam int ADDR_WIDTH_DEF = 28;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int RESET_PC_DEF   = 'h100;
  localparam int PC_STEP_DEF    = 2;

  // FETCH may issue a read, WAIT has a read on the bus, HALTED issues nothing.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO holding each word together with the PC it was fetched from.
module fetch_buffer #(
  parameter int DW = 32,
  parameter int AW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_pc,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_wr, do_rd;
  logic [1:0][DW-1:0] slot_data;
  logic [1:0][AW-1:0] slot_pc;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

  // A pop frees the slot a same-cycle push needs, and a push on an empty
  // buffer lets a same-cycle pop take effect, so occupancy stays unchanged.
  assign do_wr = push && (!full || pop);
  assign do_rd = pop && (!empty || push);

  assign head_data = slot_data[rd_ptr_q];
  assign head_pc   = slot_pc[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_wr) wr_ptr_d = ~wr_ptr_q;
      if (do_rd) rd_ptr_d = ~rd_ptr_q;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          wr_en;

    assign wr_en = do_wr && !flush && (wr_ptr_q == 1'(gi));

    // Load this slot when the write pointer selects it.
    always_comb begin
      data_d = data_q;
      pc_d   = pc_q;
      if (wr_en) begin
        data_d = push_data;
        pc_d   = push_pc;
      end
    end

    // Slot storage, cleared on reset so ir/ir_pc read zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        pc_q   <= '0;
      end else begin
        data_q <= data_d;
        pc_q   <= pc_d;
      end
    end

    assign slot_data[gi] = data_q;
    assign slot_pc[gi]   = pc_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: one registered read per issue, returned words
// buffered with their PC, redirect/halt control from the core.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int                    PC_STEP    = PC_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  busy
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  // Set in the cycle mem_rdata carries the word for mem_addr_q.
  logic                  ret_valid_q, ret_valid_d;

  logic                  buf_full, buf_empty, buf_push, buf_pop;
  logic [1:0]            buf_count, free_slots, inflight;
  logic                  can_issue;

  // A slot must be reserved for every read already on its way back.
  assign inflight   = 2'(mem_rd_q) + 2'(ret_valid_q);
  assign free_slots = 2'd2 - buf_count;
  assign can_issue  = (state_q == ST_FETCH) && !halt && !redirect &&
                      !buf_full && (free_slots > inflight);

  // Redirect beats everything: the returning word and the head pop are both void.
  assign buf_push = ret_valid_q && !redirect;
  assign buf_pop  = !buf_empty && ir_ready && !redirect;

  fetch_buffer #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (buf_push),
    .push_data (mem_rdata),
    .push_pc   (mem_addr_q),
    .pop       (buf_pop),
    .head_data (ir),
    .head_pc   (ir_pc),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Fetch state machine, PC sequencing and memory request generation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    ret_valid_d = mem_rd_q;
    if (redirect) begin
      pc_d        = redirect_pc;
      ret_valid_d = 1'b0;
      state_d     = (state_q == ST_HALTED && halt) ? ST_HALTED : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (can_issue) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);
            state_d    = ST_WAIT;
          end
        end
        // The read on the bus still returns; halting only stops new issues.
        ST_WAIT:   state_d = halt ? ST_HALTED : ST_FETCH;
        ST_HALTED: if (!halt) state_d = ST_FETCH;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  // Control and memory-interface registers; reset also drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      ret_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_cs   = mem_rd_q;
  assign mem_oe   = mem_rd_q;
  assign ir_valid = !buf_empty;
  assign busy     = mem_rd_q || ret_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for start-up/back-pressure/redirect,
// hand sequences for wrap, halt and reset mid-read, then randomized traffic.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [27:0] mem_addr;
  logic        mem_cs, mem_oe;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic [27:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [27:0] redirect_pc;
  logic        halt;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_cs      (mem_cs),
    .mem_oe      (mem_oe),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, the rest derived from the address.
  function automatic logic [31:0] mem_fn(input logic [27:0] a);
    case (a)
      28'h100: return 32'h1000011E;
      28'h102: return 32'h00000120;
      28'h118: return 32'h08000000;
      default: return {4'hA, a};
    endcase
  endfunction

  // Synchronous-read memory: data valid the cycle after a cs/oe cycle.
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_cs && mem_oe) mem_rdata <= mem_fn(mem_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next presented instruction, check it, consume it (ir_ready=1).
  task automatic expect_next(input logic [27:0] pc, input string nm);
    int n;
    n = 0;
    while (!ir_valid && n < 20) begin
      step();
      n++;
    end
    if (!ir_valid) begin
      chk({nm, "_timeout"}, 64'(ir_valid), 64'd1);
    end else begin
      $display("[TB] %s: ir_pc=%07h ir=%08h", nm, ir_pc, ir);
      chk({nm, "_pc"}, 64'(ir_pc), 64'(pc));
      chk({nm, "_ir"}, 64'(ir), 64'(mem_fn(pc)));
    end
    step();
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [27:0] rpc;
    logic        e_valid;
    logic [27:0] e_pc;
    logic        e_cs;
    logic [27:0] e_addr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] exp_pc, prev_pc;
    logic [31:0] prev_ir, r;
    logic        prev_hold, halt_applied;
    int          accepted, n;

    // Row k: inputs applied before edge k, outputs expected just after it.
    vecs[0]  = '{0, 0, 0,       0, 0,       1, 28'h100, 1};
    vecs[1]  = '{0, 0, 0,       0, 0,       0, 28'h100, 1};
    vecs[2]  = '{0, 0, 0,       1, 28'h100, 1, 28'h102, 1};
    vecs[3]  = '{0, 0, 0,       1, 28'h100, 0, 28'h102, 1};
    vecs[4]  = '{0, 0, 0,       1, 28'h100, 0, 28'h102, 0};
    vecs[5]  = '{0, 0, 0,       1, 28'h100, 0, 28'h102, 0};
    vecs[6]  = '{0, 0, 0,       1, 28'h100, 0, 28'h102, 0};
    vecs[7]  = '{0, 0, 0,       1, 28'h100, 0, 28'h102, 0};
    vecs[8]  = '{1, 0, 0,       1, 28'h102, 0, 28'h102, 0};
    vecs[9]  = '{1, 0, 0,       0, 0,       1, 28'h104, 1};
    vecs[10] = '{1, 0, 0,       0, 0,       0, 28'h104, 1};
    vecs[11] = '{1, 0, 0,       1, 28'h104, 1, 28'h106, 1};
    vecs[12] = '{1, 1, 28'h118, 0, 0,       0, 28'h106, 0};
    vecs[13] = '{1, 0, 0,       0, 0,       1, 28'h118, 1};
    vecs[14] = '{1, 0, 0,       0, 0,       0, 28'h118, 1};
    vecs[15] = '{1, 0, 0,       1, 28'h118, 1, 28'h11A, 1};

    rst = 1'b1; ir_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_valid", 64'(ir_valid), 64'd0);
    chk("rst_ir",       64'(ir),       64'd0);
    chk("rst_ir_pc",    64'(ir_pc),    64'd0);
    chk("rst_mem_cs",   64'(mem_cs),   64'd0);
    chk("rst_mem_oe",   64'(mem_oe),   64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start-up latency, back-pressure to a full buffer, release, redirect mid-read.
    for (int k = 0; k < 16; k++) begin
      ir_ready    = vecs[k].rdy;
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      step();
      $display("[TB] cycle %0d: ir_valid=%0b ir_pc=%07h ir=%08h cs=%0b addr=%07h busy=%0b",
               k + 1, ir_valid, ir_pc, ir, mem_cs, mem_addr, busy);
      chk($sformatf("t%0d_ir_valid", k + 1), 64'(ir_valid), 64'(vecs[k].e_valid));
      chk($sformatf("t%0d_mem_cs", k + 1),   64'(mem_cs),   64'(vecs[k].e_cs));
      chk($sformatf("t%0d_mem_oe", k + 1),   64'(mem_oe),   64'(vecs[k].e_cs));
      chk($sformatf("t%0d_mem_addr", k + 1), 64'(mem_addr), 64'(vecs[k].e_addr));
      chk($sformatf("t%0d_busy", k + 1),     64'(busy),     64'(vecs[k].e_busy));
      if (vecs[k].e_valid) begin
        chk($sformatf("t%0d_ir_pc", k + 1), 64'(ir_pc), 64'(vecs[k].e_pc));
        chk($sformatf("t%0d_ir", k + 1),    64'(ir),    64'(mem_fn(vecs[k].e_pc)));
      end
    end
    redirect = 1'b0;

    // PC wraps modulo 2^28.
    redirect = 1'b1; redirect_pc = 28'hFFFFFFE;
    step();
    redirect = 1'b0;
    expect_next(28'hFFFFFFE, "wrap_a");
    expect_next(28'h0000000, "wrap_b");

    // Halt: no new reads while halted, resume with nothing lost.
    redirect = 1'b1; redirect_pc = 28'h108;
    step();
    redirect = 1'b0;
    expect_next(28'h108, "pre_halt");
    ir_ready = 1'b0;
    halt = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("halt_cs_%0d", i), 64'(mem_cs), 64'd0);
    end
    chk("halt_busy", 64'(busy), 64'd0);
    halt = 1'b0;
    ir_ready = 1'b1;
    expect_next(28'h10A, "resume_a");
    expect_next(28'h10C, "resume_b");
    expect_next(28'h10E, "resume_c");

    // Reset while a read is on the bus.
    n = 0;
    while (!mem_cs && n < 10) begin
      step();
      n++;
    end
    chk("midrd_cs_seen", 64'(mem_cs), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrd_rst_cs",    64'(mem_cs),   64'd0);
    chk("midrd_rst_busy",  64'(busy),     64'd0);
    chk("midrd_rst_valid", 64'(ir_valid), 64'd0);
    chk("midrd_rst_addr",  64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_next(28'h100, "post_rst_a");
    expect_next(28'h102, "post_rst_b");

    // Randomized traffic against the in-order stream model.
    exp_pc   = 28'h104;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      ir_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) halt = !halt;
      redirect = ($urandom_range(0, 39) == 0);
      r = $urandom;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 28'hFFFFFFA : (r[27:0] & 28'hFFFFFFE);
      if (redirect) begin
        $display("[TB] redirect to %07h", redirect_pc);
        exp_pc = redirect_pc;
      end else if (ir_valid && ir_ready) begin
        $display("[TB] accept ir_pc=%07h ir=%08h", ir_pc, ir);
        chk("rnd_pc", 64'(ir_pc), 64'(exp_pc));
        chk("rnd_ir", 64'(ir),    64'(mem_fn(exp_pc)));
        exp_pc = exp_pc + 28'd2;
        accepted++;
      end
      prev_hold    = ir_valid && !ir_ready && !redirect;
      prev_pc      = ir_pc;
      prev_ir      = ir;
      halt_applied = halt;
      step();
      if (prev_hold) begin
        chk("rnd_hold_valid", 64'(ir_valid), 64'd1);
        chk("rnd_hold_pc",    64'(ir_pc),    64'(prev_pc));
        chk("rnd_hold_ir",    64'(ir),       64'(prev_ir));
      end
      if (halt_applied) chk("rnd_halt_cs", 64'(mem_cs), 64'd0);
    end
    halt = 1'b0;
    redirect = 1'b0;
    chk("rnd_progress", 64'(accepted >= 200), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
